noc_inj_port_arbiter: RTL and testbench
=======================================

# noc_inj_port_arbiter

Packet-granular round-robin arbiter that shares one endpoint injection channel (one local port of a mesh/torus/ring router) among NREQ requesters. It locks the channel from a head flit through its tail flit and tracks downstream buffer credits. It drives only registered flits into the router local port. It sits between a cluster of endpoint NIs and the `chan_in_all[ENDPID]` slot of the NoC top.

## Interface
- NREQ, 4: number of requesters (2..16).
- FLITw, 32: flit payload width.
- B, 4: downstream input-buffer depth in flits; this is the initial credit count.
- TO_CYC, 64: watchdog stall limit in cycles. Used only with the watchdog macro.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i presents a flit.
- req_flit  in  NREQ*FLITw  flit of requester i at bits [(i+1)*FLITw-1 : i*FLITw].
- req_hdr  in  NREQ  flit is a head flit.
- req_tail  in  NREQ  flit is a tail flit. hdr&tail together means a single-flit packet.
- req_ready  out  NREQ  flit of requester i is accepted this cycle. Combinational.
- out_flit_wr  out  1  registered flit write into the router local port.
- out_flit  out  FLITw  registered flit payload.
- out_hdr, out_tail  out  1 each  registered head/tail markers.
- credit_in  in  1  one downstream buffer slot freed.
- grant_id  out  clog2(NREQ)  current/last owner index.
- busy  out  1  a packet is locked in progress (state LOCK).
- proto_err  out  1  sticky protocol-violation flag.
- wd_err  out  1  sticky watchdog flag; constant 0 when the watchdog is compiled out.

## Operation
- Credit counter `cnt`, width clog2(B+1), reset value B.
  - Decrements on each accept. Increments on credit_in. Accept and credit_in in the same cycle leave it unchanged.
  - credit_in while cnt==B: ignored, and proto_err is set.
- Accept condition: req_valid[i] & req_ready[i]. At most one bit of req_ready is high. Every req_ready bit requires cnt>0.
- FSM IDLE:
  - Eligible requesters are those with valid&hdr. The winner is the first eligible index at or after `ptr`, searching circularly.
  - The winner's head flit is accepted this cycle. grant_id takes the winner, and ptr takes (winner+1) mod NREQ.
  - Next state is LOCK unless the flit also has tail. Single-flit packets stay in IDLE.
  - A valid non-head flit in IDLE is never accepted; it remains pending.
- FSM LOCK:
  - Only grant_id may be accepted.
  - Accepting a tail flit moves the FSM to IDLE.
  - A head flit from the owner without tail is forwarded as a body flit and sets proto_err.
  - Other requesters see ready=0.
- ptr reset value is 0. It wraps from NREQ-1 to 0.
- proto_err and wd_err clear only on reset.

## Timing
- Latency is 1 cycle: a flit accepted at edge n appears on out_* during cycle n+1, with out_flit_wr=1.
- The output register is bypassed by nothing. out_flit_wr=0 on any cycle following a non-accept cycle.
- Back-to-back packets are possible. A tail in cycle n and a new head (any requester) in cycle n+1 give full throughput when credits are available.
- Reset values:
  - out_flit_wr, out_flit, out_hdr, out_tail, grant_id, busy, proto_err, wd_err = 0.
  - req_ready = 0 while reset is asserted.
  - cnt = B, ptr = 0, state = IDLE.
- Reset asserted mid-packet aborts immediately: the partial packet is not completed and the credit count returns to B.

## Configuration
- INJ_ARB_WATCHDOG_EN defined:
  - In LOCK, a counter increments on each cycle the owner has req_valid=0 while cnt>0. Any accept clears it.
  - When the counter reaches TO_CYC, the FSM is forced to IDLE, wd_err is set, and ptr is unchanged. No flit is emitted, so downstream sees a truncated packet.
- INJ_ARB_WATCHDOG_EN undefined: no counter is built, wd_err is tied to 0, and LOCK waits indefinitely.

## Test plan
- Single-flit fairness: NREQ=4, all four requesters hold hdr&tail valid, credit_in is pulsed every cycle → grants 0,1,2,3,0, one per cycle; out_flit_wr high every cycle after the first.
- Packet lock: req0 sends a 3-flit packet while req1 holds a head → req1 ready stays 0 until the cycle after req0's tail accept; req1's head appears on out_* 2 cycles after req0's tail was accepted.
- Credit exhaustion: B=4, no credit_in, req0 sends 6 body flits → exactly 4 accepted, then ready=0. One credit_in pulse → exactly 1 more accept.
- Simultaneous accept and credit: with cnt=1, an accept and credit_in in the same cycle → cnt stays 1, and the next flit is accepted.
- Errors: credit_in at cnt=B sets proto_err; a non-head flit in IDLE is never accepted; reset asserted mid-packet → busy=0, cnt=B, and ptr=0 after release.
- Watchdog (macro defined, TO_CYC=64): req0 sends a head, then drops valid for 64 cycles → wd_err=1, busy=0, and a req1 head is then granted.

Source files
------------

// File: rtl/noc_inj_port_arbiter_if.sv
// Handshake bundle between the requester-side endpoint NIs, the arbiter and the router
// local injection port.
//
// Signals:
//   req_valid/req_hdr/req_tail [NREQ]  per-requester flit valid and head/tail markers
//   req_flit [NREQ*FLITw]              requester i occupies bits [(i+1)*FLITw-1 : i*FLITw]
//   req_ready [NREQ]                   per-requester accept (driven by the arbiter)
//   out_flit_wr/out_flit/out_hdr/out_tail  registered flit into the router local port
//   credit_in                          one downstream buffer slot freed
// Modports:
//   master  requesters + router side (drives requests and credits)
//   slave   the arbiter
interface noc_inj_port_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned FLITw = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*FLITw-1:0] req_flit;
  logic [NREQ-1:0]       req_hdr;
  logic [NREQ-1:0]       req_tail;
  logic [NREQ-1:0]       req_ready;
  logic                  out_flit_wr;
  logic [FLITw-1:0]      out_flit;
  logic                  out_hdr;
  logic                  out_tail;
  logic                  credit_in;

  modport master (
    output req_valid, req_flit, req_hdr, req_tail, credit_in,
    input  req_ready, out_flit_wr, out_flit, out_hdr, out_tail
  );

  modport slave (
    input  req_valid, req_flit, req_hdr, req_tail, credit_in,
    output req_ready, out_flit_wr, out_flit, out_hdr, out_tail
  );
endinterface

// File: rtl/noc_inj_port_arbiter.sv
// Packet-granular round-robin arbiter sharing one router injection port among NREQ
// requesters. A head flit locks the channel to its owner until the tail flit; downstream
// buffer space is tracked with a credit counter starting at B. Flits leave through a
// single output register (1-cycle latency).
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   bus_io       request/response and output-port bundle (slave modport)
//   grant_id_o   current/last owner index
//   busy_o       packet locked in progress
//   proto_err_o  sticky protocol violation (credit overflow, head inside a packet)
//   wd_err_o     sticky watchdog abort flag
//
// Build option: define INJ_ARB_WATCHDOG_EN to abort packets whose owner stalls for TO_CYC
// cycles; otherwise wd_err_o is tied to 0 and a locked packet waits indefinitely.
module noc_inj_port_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned FLITw  = 32,
  parameter int unsigned B      = 4,
  parameter int unsigned TO_CYC = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  noc_inj_port_arbiter_if.slave   bus_io,
  output logic [$clog2(NREQ)-1:0] grant_id_o,
  output logic                    busy_o,
  output logic                    proto_err_o,
  output logic                    wd_err_o
);
  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(B + 1);

  if (NREQ < 2 || NREQ > 16 || TO_CYC < 1) begin : g_param_check
    $error("noc_inj_port_arbiter: illegal parameter set");
  end

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d, grant_q, grant_d;
  logic [IdxW-1:0]   win_idx, acc_idx;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              proto_err_q, proto_err_d;
  logic              win_found;
  logic [NREQ-1:0]   elig, ready;
  logic              accept, acc_hdr, acc_tail, wd_abort;
  logic [FLITw-1:0]  acc_flit;
  logic              out_wr_q, out_hdr_q, out_tail_q;
  logic [FLITw-1:0]  out_flit_q;

  assign elig = bus_io.req_valid & bus_io.req_hdr;

  // Circular search for the first eligible head at or after ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      int j;
      j = (int'(ptr_q) + k) % int'(NREQ);
      if (!win_found && elig[j]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(j);
      end
    end
  end

  always_comb begin
    ready   = '0;
    acc_idx = (state_q == StIdle) ? win_idx : grant_q;
    if (cnt_q != '0) begin
      if (state_q == StIdle) ready[win_idx] = win_found;
      else                   ready[grant_q] = 1'b1;
    end
  end

  // Ready is forced low while reset is held, even though the state is already at reset.
  assign bus_io.req_ready = ready & {NREQ{rst_ni}};
  assign accept           = |(bus_io.req_valid & bus_io.req_ready);
  assign acc_flit         = bus_io.req_flit[32'(acc_idx) * FLITw +: FLITw];
  assign acc_hdr          = bus_io.req_hdr[acc_idx];
  assign acc_tail         = bus_io.req_tail[acc_idx];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          grant_d = win_idx;
          ptr_d   = (win_idx == IdxW'(NREQ - 1)) ? '0 : win_idx + IdxW'(1);
          if (!acc_tail) state_d = StLock;
        end
      end
      StLock: begin
        if (accept) begin
          if (acc_tail)     state_d     = StIdle;
          else if (acc_hdr) proto_err_d = 1'b1;  // forwarded as a body flit
        end else if (wd_abort) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    case ({accept, bus_io.credit_in})
      2'b10: cnt_d = cnt_q - CntW'(1);
      2'b01: begin
        if (cnt_q == CntW'(B)) proto_err_d = 1'b1;
        else                   cnt_d       = cnt_q + CntW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= CntW'(B);
      proto_err_q <= 1'b0;
      out_wr_q    <= 1'b0;
      out_flit_q  <= '0;
      out_hdr_q   <= 1'b0;
      out_tail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
      out_wr_q    <= accept;
      if (accept) begin
        out_flit_q <= acc_flit;
        out_hdr_q  <= acc_hdr;
        out_tail_q <= acc_tail;
      end
    end
  end

`ifdef INJ_ARB_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TO_CYC + 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_err_q, stall;

  // Stalls without credits are the router's fault, not the owner's, so they are not counted.
  assign stall    = (state_q == StLock) && !bus_io.req_valid[grant_q] && (cnt_q != '0);
  assign wd_abort = stall && (wd_cnt_q == WdW'(TO_CYC - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q != StLock || accept || wd_abort) wd_cnt_d = '0;
    else if (stall)                              wd_cnt_d = wd_cnt_q + WdW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_abort) wd_err_q <= 1'b1;
    end
  end

  assign wd_err_o = wd_err_q;
`else
  assign wd_abort = 1'b0;
  assign wd_err_o = 1'b0;
`endif

  assign bus_io.out_flit_wr = out_wr_q;
  assign bus_io.out_flit    = out_flit_q;
  assign bus_io.out_hdr     = out_hdr_q;
  assign bus_io.out_tail    = out_tail_q;
  assign grant_id_o         = grant_q;
  assign busy_o             = (state_q == StLock);
  assign proto_err_o        = proto_err_q;
endmodule

// File: tb/tb_noc_inj_port_arbiter.sv
// Bench for noc_inj_port_arbiter: directed stimulus, expected output flits queued when an
// accept is predicted and compared when the output register is due to show them.
module tb_noc_inj_port_arbiter;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned FLITw  = 32;
  localparam int unsigned B      = 4;
  localparam int unsigned TO_CYC = 64;

  typedef struct {
    int unsigned      due;
    logic [FLITw-1:0] flit;
    logic             hdr;
    logic             tail;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant_id;
  logic       busy, proto_err, wd_err;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  noc_inj_port_arbiter_if #(.NREQ(NREQ), .FLITw(FLITw)) bus ();

  noc_inj_port_arbiter #(
    .NREQ  (NREQ),
    .FLITw (FLITw),
    .B     (B),
    .TO_CYC(TO_CYC)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus_io     (bus),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .proto_err_o(proto_err),
    .wd_err_o   (wd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic drv(input int i, input bit v, input bit h, input bit t,
                     input logic [FLITw-1:0] f);
    bus.req_valid[i]                = v;
    bus.req_hdr[i]                  = h;
    bus.req_tail[i]                 = t;
    bus.req_flit[i*FLITw +: FLITw]  = f;
  endtask

  task automatic clr_all();
    for (int i = 0; i < NREQ; i++) drv(i, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Called with inputs already set just after a rising edge; checks ready mid-cycle, queues
  // predicted accepts, and returns just after the next rising edge.
  task automatic tick(input string tag, input logic [NREQ-1:0] exp_rdy, input bit do_chk);
    @(negedge clk);
    if (do_chk) chk(tag, 64'(bus.req_ready), 64'(exp_rdy));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i] && bus.req_valid[i])
        sb_q.push_back('{due: cyc + 1, flit: bus.req_flit[i*FLITw +: FLITw],
                         hdr: bus.req_hdr[i], tail: bus.req_tail[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic credit_pulse(input string tag);
    bus.credit_in = 1'b1;
    tick(tag, 4'b0000, 1'b1);
    bus.credit_in = 1'b0;
  endtask

  // Output monitor: each queued flit must appear exactly in its due cycle, nothing else.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        chk("out_missing", 64'(0), 64'(1));
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        mon_e = sb_q.pop_front();
        chk("out_wr",   64'(bus.out_flit_wr), 64'(1));
        chk("out_flit", 64'(bus.out_flit),    64'(mon_e.flit));
        chk("out_hdr",  64'(bus.out_hdr),     64'(mon_e.hdr));
        chk("out_tail", 64'(bus.out_tail),    64'(mon_e.tail));
      end else begin
        chk("out_wr_idle", 64'(bus.out_flit_wr), 64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [NREQ-1:0] er;
    rst_n         = 1'b0;
    bus.credit_in = 1'b0;
    for (int i = 0; i < NREQ; i++) drv(i, 1'b1, 1'b1, 1'b1, 32'hDEAD_0000 | i);
    #3;
    chk("rst_ready",   64'(bus.req_ready),   64'(0));
    chk("rst_wr",      64'(bus.out_flit_wr), 64'(0));
    chk("rst_flit",    64'(bus.out_flit),    64'(0));
    chk("rst_hdr",     64'(bus.out_hdr),     64'(0));
    chk("rst_tail",    64'(bus.out_tail),    64'(0));
    chk("rst_grant",   64'(grant_id),        64'(0));
    chk("rst_busy",    64'(busy),            64'(0));
    chk("rst_perr",    64'(proto_err),       64'(0));
    chk("rst_wderr",   64'(wd_err),          64'(0));
    clr_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-flit fairness with a credit returned every cycle.
    bus.credit_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NREQ; i++) drv(i, 1'b1, 1'b1, 1'b1, 32'hA000_0000 | (k << 8) | i);
      er = '0;
      er[k % NREQ] = 1'b1;
      tick("fair_rdy", er, 1'b1);
      chk("fair_grant", 64'(grant_id), 64'(k % NREQ));
    end
    bus.credit_in = 1'b0;
    clr_all();
    chk("fair_perr", 64'(proto_err), 64'(0));

    // Packet lock: req0 3-flit packet, req1 head waits until req0's tail is accepted.
    drv(0, 1'b1, 1'b1, 1'b0, 32'hB000_0000);
    tick("lock_h", 4'b0001, 1'b1);
    chk("lock_busy", 64'(busy), 64'(1));
    chk("lock_grant", 64'(grant_id), 64'(0));
    bus.credit_in = 1'b1;
    drv(0, 1'b1, 1'b0, 1'b0, 32'hB000_0001);
    drv(1, 1'b1, 1'b1, 1'b1, 32'hB100_0000);
    tick("lock_b", 4'b0001, 1'b1);
    drv(0, 1'b1, 1'b0, 1'b1, 32'hB000_0002);
    tick("lock_t", 4'b0001, 1'b1);
    chk("lock_idle", 64'(busy), 64'(0));
    drv(0, 1'b0, 1'b0, 1'b0, '0);
    tick("lock_r1", 4'b0010, 1'b1);
    chk("lock_grant1", 64'(grant_id), 64'(1));
    bus.credit_in = 1'b0;
    clr_all();
    credit_pulse("lock_refill");

    // Credit exhaustion: 4 credits, then one per credit pulse.
    drv(0, 1'b1, 1'b1, 1'b0, 32'hC000_0000);
    tick("cr_h", 4'b0001, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      drv(0, 1'b1, 1'b0, 1'b0, 32'hC000_0000 | k);
      tick("cr_b", 4'b0001, 1'b1);
    end
    drv(0, 1'b1, 1'b0, 1'b0, 32'hC000_0004);
    tick("cr_empty", 4'b0000, 1'b1);
    tick("cr_empty", 4'b0000, 1'b1);
    credit_pulse("cr_pulse");
    tick("cr_one", 4'b0001, 1'b1);
    drv(0, 1'b1, 1'b0, 1'b0, 32'hC000_0005);
    tick("cr_empty2", 4'b0000, 1'b1);
    drv(0, 1'b1, 1'b0, 1'b1, 32'hC000_0006);
    bus.credit_in = 1'b1;
    tick("cr_pulse2", 4'b0000, 1'b1);
    tick("cr_simul", 4'b0001, 1'b1);  // cnt=1: accept plus credit keeps it at 1
    bus.credit_in = 1'b0;
    chk("cr_tail_idle", 64'(busy), 64'(0));
    drv(0, 1'b1, 1'b1, 1'b1, 32'hC000_0007);
    tick("cr_after_simul", 4'b0001, 1'b1);
    drv(0, 1'b1, 1'b1, 1'b1, 32'hC000_0008);
    tick("cr_empty3", 4'b0000, 1'b1);
    clr_all();
    repeat (4) credit_pulse("cr_refill");
    chk("cr_perr", 64'(proto_err), 64'(0));

    // Non-head flit in IDLE is never accepted; credit overflow sets proto_err.
    drv(2, 1'b1, 1'b0, 1'b0, 32'hD200_0000);
    tick("nh_idle", 4'b0000, 1'b1);
    tick("nh_idle", 4'b0000, 1'b1);
    drv(3, 1'b1, 1'b1, 1'b1, 32'hD300_0000);
    tick("nh_other", 4'b1000, 1'b1);
    drv(3, 1'b0, 1'b0, 1'b0, '0);
    tick("nh_still", 4'b0000, 1'b1);
    clr_all();
    credit_pulse("ovf_ok");
    chk("ovf_before", 64'(proto_err), 64'(0));
    credit_pulse("ovf");
    chk("ovf_perr", 64'(proto_err), 64'(1));

    // Reset mid-packet.
    drv(1, 1'b1, 1'b1, 1'b0, 32'hE100_0000);
    tick("mid_h", 4'b0010, 1'b1);
    drv(1, 1'b0, 1'b0, 1'b0, '0);
    tick("mid_stall", 4'b0000, 1'b0);
    chk("mid_busy", 64'(busy), 64'(1));
    drv(1, 1'b1, 1'b0, 1'b0, 32'hE100_0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  64'(busy),          64'(0));
    chk("mid_rst_perr",  64'(proto_err),     64'(0));
    chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
    clr_all();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) drv(i, 1'b1, 1'b1, 1'b1, 32'hF000_0000 | i);
    tick("post_ptr0", 4'b0001, 1'b1);
    chk("post_grant", 64'(grant_id), 64'(0));
    clr_all();
    credit_pulse("post_cr");
    chk("post_cnt_b_a", 64'(proto_err), 64'(0));
    credit_pulse("post_ovf");
    chk("post_cnt_b_b", 64'(proto_err), 64'(1));

`ifdef INJ_ARB_WATCHDOG_EN
    drv(0, 1'b1, 1'b1, 1'b0, 32'h9000_0000);
    tick("wd_h", 4'b0001, 1'b1);
    drv(0, 1'b0, 1'b0, 1'b0, '0);
    repeat (TO_CYC - 1) tick("wd_stall", 4'b0000, 1'b0);
    chk("wd_busy_pre", 64'(busy),   64'(1));
    chk("wd_err_pre",  64'(wd_err), 64'(0));
    tick("wd_stall", 4'b0000, 1'b0);
    chk("wd_busy", 64'(busy),   64'(0));
    chk("wd_err",  64'(wd_err), 64'(1));
    drv(1, 1'b1, 1'b1, 1'b1, 32'h9100_0000);
    tick("wd_next", 4'b0010, 1'b1);
    chk("wd_grant", 64'(grant_id), 64'(1));
    clr_all();
`else
    chk("wd_tied", 64'(wd_err), 64'(0));
`endif

    tick("drain", 4'b0000, 1'b1);
    tick("drain", 4'b0000, 1'b1);
    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
